// File: rtl/gray_bin_pipe_pkg.sv
// Shared definitions for the Gray/binary pipeline: mode encodings and
// width-generic conversion helpers operating on a zero-extended code type.
package gray_pkg;

    // Widest code the helpers handle; blocks must use WIDTH < MAX_W.
    localparam int MAX_W = 64;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    typedef logic [MAX_W-1:0] code_t;

    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it; zero
    // upper bits leave the running parity untouched.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        logic  acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input code_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_bin_pipe_if.sv
// Input and output handshake channels of the Gray/binary pipeline.
interface gray_bin_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
    logic             out_step_err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_step_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_step_err
    );
endinterface

// File: rtl/gray_bin_pipe_step_checker.sv
// Gray-domain adjacency tracker: compares each advancing code with the
// previous one and keeps a saturating count of multi-bit steps.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [WIDTH-1:0]    gray_i,
    output logic                step_err_o,
    output logic [ERRCNT_W-1:0] err_count_o
);
    logic [WIDTH-1:0]    last_gray_q;
    logic                hist_valid_q;
    logic [ERRCNT_W-1:0] err_count_q;
    logic [ERRCNT_W-1:0] err_count_d;
    logic                multi_bit;

    assign multi_bit = popcount(code_t'(gray_i ^ last_gray_q)) >= 2;

    // A clear in the same cycle empties the history before this word is judged.
    assign step_err_o = hist_valid_q & ~clear_i & multi_bit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        err_count_d = err_count_q;
        if (clear_i) begin
            err_count_d = '0;
        end else if (advance_i && step_err_o && !(&err_count_q)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gray_q  <= '0;
            hist_valid_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_count_q <= err_count_d;
            if (advance_i) begin
                last_gray_q  <= gray_i;
                hist_valid_q <= 1'b1;
            end else if (clear_i) begin
                hist_valid_q <= 1'b0;
            end
        end
    end

    assign err_count_o = err_count_q;

endmodule

// File: rtl/gray_bin_pipe.sv
// Two-stage registered Gray<->binary converter with valid/ready on both
// sides, per-word mode select and Gray step-error tracking.
module gray_bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    gray_bin_pipe_if.slave      bus,
    output logic [ERRCNT_W-1:0] err_count
);
    logic             s1_valid_q;
    logic             s1_mode_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s2_valid_q;
    logic             s2_mode_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_err_q;

    logic             s1_load;
    logic             s2_load;
    code_t            s1_ext;
    code_t            bin_full;
    code_t            gray_full;
    logic [WIDTH-1:0] s1_conv;
    logic [WIDTH-1:0] s1_gray;
    logic             step_err;
    logic             unused_hi;

    // S2 takes a word when it is empty or its word leaves this cycle; that
    // same event frees S1, so in_ready depends combinationally on out_ready.
    assign s2_load      = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign bus.in_ready = ~s1_valid_q | s2_load;
    assign s1_load      = bus.in_valid & bus.in_ready;

    assign s1_ext    = code_t'(s1_data_q);
    assign bin_full  = gray2bin(s1_ext);
    assign gray_full = bin2gray(s1_ext);
    assign unused_hi = ^{bin_full[MAX_W-1:WIDTH], gray_full[MAX_W-1:WIDTH]};

    // The step checker always sees the Gray form of the word, whichever
    // direction it is being converted.
    always_comb begin
        s1_conv = gray_full[WIDTH-1:0];
        s1_gray = gray_full[WIDTH-1:0];
        if (s1_mode_q == MODE_G2B) begin
            s1_conv = bin_full[WIDTH-1:0];
            s1_gray = s1_data_q;
        end
    end

    gray_step_checker #(
        .WIDTH    (WIDTH),
        .ERRCNT_W (ERRCNT_W)
    ) u_step_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .advance_i   (s2_load),
        .gray_i      (s1_gray),
        .step_err_o  (step_err),
        .err_count_o (err_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_B2G;
            s1_data_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_mode_q  <= bus.in_mode;
            s1_data_q  <= bus.in_data;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Payload registers only change on a load, which keeps out_* stable
    // while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= MODE_B2G;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_mode_q  <= s1_mode_q;
            s2_data_q  <= s1_conv;
            s2_err_q   <= step_err;
        end else if (bus.out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.out_mode     = s2_mode_q;
    assign bus.out_data     = s2_data_q;
    assign bus.out_step_err = s2_err_q;

endmodule
